// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered one-hot grant.
//
// A rotating priority pointer makes the most recently granted requester the
// lowest priority on the next arbitration, so no requester can be starved.
//
// Optional feature (macro RR_ARB_LOCK_EN): grant locking. While the granted
// requester keeps its request asserted, the grant stays with it for up to
// MAX_HOLD consecutive cycles. After that, normal arbitration resumes.
//
// Parameters:
//   NUM_REQ   number of requesters (2..32)
//   MAX_HOLD  longest locked grant in cycles (1..255); used only with the lock
//   ID_W      width of grant_id (derived)
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   req          level-sensitive request vector, bit i = requester i
//   grant        registered one-hot grant, or all zeros
//   grant_valid  registered, equals |grant
//   grant_id     registered index of the granted bit, 0 when no grant
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    // Elaboration-time checks of the legal parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 32) begin : g_bad_num_req
        $error("rr_arbiter: NUM_REQ must be in 2..32");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter: MAX_HOLD must be in 1..255");
    end

    // The extended width leaves room for ptr+k before the wrap compare.
    // That keeps the search correct when NUM_REQ is not a power of two.
    localparam logic [ID_W:0]   N_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST  = ID_W'(NUM_REQ-1);

    logic [ID_W-1:0] ptr;
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] next_ptr;
    logic            hold;

    // Search req from ptr upward, wrapping at NUM_REQ. The first set bit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= N_EXT) idx = idx - N_EXT;
            if (!found && req[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (win == LAST) ? '0 : win + ID_W'(1);

`ifdef RR_ARB_LOCK_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    logic [7:0] hold_cnt;

    // Keep the grant while its owner still requests and has hold budget left.
    assign hold = grant_valid && req[grant_id] && (hold_cnt < HOLD_LIM);

    // The count is 1 on a fresh grant and increments on each held cycle.
    // It returns to 0 when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      hold_cnt <= '0;
        else if (hold)  hold_cnt <= hold_cnt + 8'd1;
        else if (found) hold_cnt <= 8'd1;
        else            hold_cnt <= '0;
    end
`else
    assign hold = 1'b0;
`endif

    // While the grant is held, every register keeps its value.
    // An empty request vector clears the grant but leaves ptr alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
        end else if (!hold) begin
            if (found) begin
                grant       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                grant_valid <= 1'b1;
                grant_id    <= win;
                ptr         <= next_ptr;
            end else begin
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_id    <= '0;
            end
        end
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised round-robin arbiter for NUM_REQ requesters with a registered one-hot grant. It replaces fixed-priority request/grant logic wherever several masters share one resource and starvation is not acceptable. A rotating priority pointer makes the most recently granted requester lowest priority on the next arbitration. Optional grant locking keeps a multi-cycle transfer on one requester, bounded by a hold limit.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold a locked grant; legal range 1..255. Used only with RR_ARB_LOCK_EN.
- ID_W, $clog2(NUM_REQ), width of grant_id. Derived; not overridden.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i is requester i. Level-sensitive, sampled at each rising edge.
- grant  output  NUM_REQ  registered one-hot grant, or all zeros.
- grant_valid  output  1  registered; equals |grant.
- grant_id  output  ID_W  registered binary index of the granted bit; 0 when grant_valid is 0.

## Operation
- State:
  - ptr [ID_W-1:0] is the highest-priority index.
  - grant, grant_id and grant_valid registers.
  - hold_cnt [7:0], present only with RR_ARB_LOCK_EN.
- Reset (asynchronous, applies immediately whenever reset is high, including mid-grant):
  - grant=0, grant_valid=0, grant_id=0, ptr=0, hold_cnt=0.
  - First arbitration happens at the first rising edge after reset deasserts.
- Arbitration, evaluated every edge:
  - Search req from index ptr upward, wrapping from NUM_REQ-1 to 0.
  - The first set bit w wins: grant<=1<<w, grant_id<=w, grant_valid<=1.
  - ptr<=(w+1) mod NUM_REQ. When w=NUM_REQ-1, ptr wraps to 0.
- No request (req=0): grant<=0, grant_valid<=0, grant_id<=0, ptr unchanged.
- Single requester: it is granted every cycle it requests, whatever ptr holds.
- Simultaneous requests: exactly one grant bit is ever set. Under continuous all-ones req, the grant cycles through 0,1,...,NUM_REQ-1,0,...
- Request drop: with locking compiled out, dropping req removes the grant on the next edge. There is no revoke handshake.
- ptr modulo arithmetic uses ID_W bits plus an explicit wrap compare, so it stays correct for non-power-of-2 NUM_REQ.
- Bits of req are used only below index NUM_REQ; there are no unused-index grants.

## Timing
- Latency: req sampled at edge k gives grant visible after edge k (one cycle). There is no combinational path from req to the outputs.
- grant, grant_valid and grant_id change together on the same edge.
- Reset deassertion mid-transfer: the next edge arbitrates from ptr=0.
- Throughput: one arbitration decision per cycle. With locking compiled out, back-to-back grants to different requesters need no idle cycle.

## Configuration
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - While grant[i]=1 and req[i] stays 1, the grant is held on i, and ptr and grant_id stay unchanged.
  - hold_cnt counts cycles held. It is 1 on the initial grant and increments on each held cycle.
  - When hold_cnt reaches MAX_HOLD, the next edge performs normal arbitration. Requester i is then lowest priority because ptr=i+1.
  - If i is the sole requester at that point, it is re-granted with hold_cnt=1.
  - If req[i] drops, the next edge arbitrates normally.
  - hold_cnt resets to 0 when there is no grant.
- Undefined:
  - Re-arbitration happens every cycle and hold_cnt is not present.
  - MAX_HOLD is ignored.

## Test plan
- Reset: assert reset mid-grant with req=4'b1111 -> grant=0, grant_valid=0, grant_id=0 immediately, without waiting for a clock edge. After release, the first grant is 4'b0001.
- Rotation, no lock, NUM_REQ=4, req=4'b1111 for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000, with grant_id 0,1,2,3,0,1,2,3.
- Wrap and skip: ptr=3 after granting 2, req=4'b0101 -> grant 0001, then ptr=1. The next cycle with the same req -> grant 0100.
- Idle: req=0 for 3 cycles after granting 1 -> grant_valid=0 throughout and ptr stays 2. Then req=4'b0011 -> grant 0001.
- Lock (RR_ARB_LOCK_EN, MAX_HOLD=3), req=4'b0011 steady -> grant 0001 for 3 cycles, then 0010 for 3 cycles, then 0001 again.
- Lock release: with the grant held on 1, drop req[1] while req[3]=1 -> grant 1000 on the next edge. Sole requester 3 past MAX_HOLD=3 -> the grant stays 1000 continuously and hold_cnt restarts at 1.
